// File: rtl/ras_if.sv
// Return-address-stack bus: push/pop/rollback requests, ra tracking and status.
// master drives requests and reads status; slave is the stack itself.
interface ras_if #(
    parameter int WIDTH = 32
);
    logic             PL_stall;
    logic             RAS_push;
    logic [WIDTH-1:0] RAS_push_data;
    logic             RAS_pop;
    logic             RAS_rollback_pop_id;
    logic             RAS_rollback_push_id;
    logic             RAS_rollback_push_ex;
    logic             WR_ra_track_en;
    logic [4:0]       WR_ra_track_data;
    logic [WIDTH-1:0] RAS_top;
    logic             RAS_empty;
    logic             RAS_full;
    logic [4:0]       RAS_ra_track;

    modport master (
        output PL_stall, RAS_push, RAS_push_data, RAS_pop,
        output RAS_rollback_pop_id, RAS_rollback_push_id,
        output RAS_rollback_push_ex,
        output WR_ra_track_en, WR_ra_track_data,
        input  RAS_top, RAS_empty, RAS_full, RAS_ra_track
    );

    modport slave (
        input  PL_stall, RAS_push, RAS_push_data, RAS_pop,
        input  RAS_rollback_pop_id, RAS_rollback_push_id,
        input  RAS_rollback_push_ex,
        input  WR_ra_track_en, WR_ra_track_data,
        output RAS_top, RAS_empty, RAS_full, RAS_ra_track
    );
endinterface

// File: rtl/ras.sv
// Return address stack: circular buffer with overwrite-on-full, pop history
// for ID/EX rollback, and an ra-tracking register. Ports: clk, rst, bus (slave).
module ras #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic   clk,
    input  logic   rst,
    ras_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    tp, tp_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] hist_id, hist_ex;
    logic [4:0]       ra_track;
    logic [WIDTH-1:0] top;

    logic             wr0_en, wr1_en;
    logic [AW-1:0]    wr0_idx, wr1_idx;
    logic [WIDTH-1:0] wr0_data, wr1_data;
    logic             rollback;

    assign top      = (cnt == '0) ? '0 : mem[tp];
    assign rollback = bus.RAS_rollback_pop_id | bus.RAS_rollback_push_id |
                      bus.RAS_rollback_push_ex;

    // Rollback steps run youngest-first on tp_n/cnt_n, so each step sees
    // the pointer left by the previous one.
    always_comb begin
        tp_n     = tp;
        cnt_n    = cnt;
        wr0_en   = 1'b0;
        wr0_idx  = tp;
        wr0_data = '0;
        wr1_en   = 1'b0;
        wr1_idx  = tp;
        wr1_data = '0;
        if (rollback) begin
            if (bus.RAS_rollback_pop_id && bus.RAS_rollback_push_id) begin
                // undo of a same-cycle push+pop: restore the overwritten slot
                wr0_en   = 1'b1;
                wr0_idx  = tp;
                wr0_data = hist_id;
            end else begin
                if (bus.RAS_rollback_pop_id && cnt != '0) begin
                    tp_n  = tp - 1'b1;
                    cnt_n = cnt - 1'b1;
                end
                if (bus.RAS_rollback_push_id) begin
                    tp_n     = tp_n + 1'b1;
                    wr0_en   = 1'b1;
                    wr0_idx  = tp_n;
                    wr0_data = hist_id;
                    if (cnt_n != FULL_CNT) cnt_n = cnt_n + 1'b1;
                end
            end
            if (bus.RAS_rollback_push_ex) begin
                tp_n     = tp_n + 1'b1;
                wr1_en   = 1'b1;
                wr1_idx  = tp_n;
                wr1_data = hist_ex;
                if (cnt_n != FULL_CNT) cnt_n = cnt_n + 1'b1;
            end
        end else if (bus.RAS_push && bus.RAS_pop && cnt != '0) begin
            wr0_en   = 1'b1;
            wr0_idx  = tp;
            wr0_data = bus.RAS_push_data;
        end else if (bus.RAS_push) begin
            tp_n     = tp + 1'b1;
            wr0_en   = 1'b1;
            wr0_idx  = tp_n;
            wr0_data = bus.RAS_push_data;
            if (cnt != FULL_CNT) cnt_n = cnt + 1'b1;
        end else if (bus.RAS_pop && cnt != '0) begin
            tp_n  = tp - 1'b1;
            cnt_n = cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tp       <= '0;
            cnt      <= '0;
            hist_id  <= '0;
            hist_ex  <= '0;
            ra_track <= 5'd1;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            tp  <= tp_n;
            cnt <= cnt_n;
            if (wr0_en) mem[wr0_idx] <= wr0_data;
            if (wr1_en) mem[wr1_idx] <= wr1_data;
            if (!bus.PL_stall) begin
                hist_id <= bus.RAS_pop ? top : '0;
                hist_ex <= hist_id;
            end
            if (bus.WR_ra_track_en) ra_track <= bus.WR_ra_track_data;
        end
    end

    assign bus.RAS_top      = top;
    assign bus.RAS_empty    = (cnt == '0);
    assign bus.RAS_full     = (cnt == FULL_CNT);
    assign bus.RAS_ra_track = ra_track;
endmodule

// File: tb/tb_ras.sv
// Testbench for ras: directed scenarios plus randomized run against a
// queue-based reference model of the return-address stack.
module tb_ras;
    localparam int DEPTH = 8;
    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total  = 0;

    ras_if #(.WIDTH(WIDTH)) bus ();

    ras #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_hist_id, m_hist_ex;
    logic [4:0]       m_ra;

    task automatic idle();
        bus.PL_stall             = 1'b0;
        bus.RAS_push             = 1'b0;
        bus.RAS_push_data        = '0;
        bus.RAS_pop              = 1'b0;
        bus.RAS_rollback_pop_id  = 1'b0;
        bus.RAS_rollback_push_id = 1'b0;
        bus.RAS_rollback_push_ex = 1'b0;
        bus.WR_ra_track_en       = 1'b0;
        bus.WR_ra_track_data     = '0;
    endtask

    task automatic push_q(input logic [WIDTH-1:0] v);
        q.push_back(v);
        if (q.size() > DEPTH) void'(q.pop_front());
    endtask

    function automatic logic [WIDTH-1:0] m_top();
        return (q.size() == 0) ? '0 : q[q.size()-1];
    endfunction

    task automatic model_step();
        logic [WIDTH-1:0] old_top;
        old_top = m_top();
        if (bus.RAS_rollback_pop_id || bus.RAS_rollback_push_id ||
            bus.RAS_rollback_push_ex) begin
            if (bus.RAS_rollback_pop_id && bus.RAS_rollback_push_id) begin
                if (q.size() != 0) q[q.size()-1] = m_hist_id;
            end else begin
                if (bus.RAS_rollback_pop_id && q.size() != 0)
                    void'(q.pop_back());
                if (bus.RAS_rollback_push_id) push_q(m_hist_id);
            end
            if (bus.RAS_rollback_push_ex) push_q(m_hist_ex);
        end else if (bus.RAS_push && bus.RAS_pop && q.size() != 0) begin
            q[q.size()-1] = bus.RAS_push_data;
        end else if (bus.RAS_push) begin
            push_q(bus.RAS_push_data);
        end else if (bus.RAS_pop && q.size() != 0) begin
            void'(q.pop_back());
        end
        if (!bus.PL_stall) begin
            m_hist_ex = m_hist_id;
            m_hist_id = bus.RAS_pop ? old_top : '0;
        end
        if (bus.WR_ra_track_en) m_ra = bus.WR_ra_track_data;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        q.delete();
        m_hist_id = '0;
        m_hist_ex = '0;
        m_ra      = 5'd1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (bus.RAS_top !== '0) $display("FAIL reset_top got %h want 0", bus.RAS_top);
        else passed++;
        total++;
        if (bus.RAS_empty !== 1'b1 || bus.RAS_full !== 1'b0)
            $display("FAIL reset_flags got e=%b f=%b want e=1 f=0", bus.RAS_empty, bus.RAS_full);
        else passed++;
        total++;
        if (bus.RAS_ra_track !== 5'd1) $display("FAIL reset_ra got %0d want 1", bus.RAS_ra_track);
        else passed++;
        rst = 1'b0;
    endtask

    task automatic test_push_pop();
        logic [WIDTH-1:0] vals [3];
        vals = '{32'h100, 32'h200, 32'h300};
        do_reset();
        foreach (vals[i]) begin
            bus.RAS_push = 1'b1;
            bus.RAS_push_data = vals[i];
            cycle();
        end
        idle();
        total++;
        if (bus.RAS_top !== 32'h300 || int'(dut.cnt) !== 3)
            $display("FAIL push3 got top=%h cnt=%0d want top=300 cnt=3", bus.RAS_top, dut.cnt);
        else passed++;
        bus.RAS_pop = 1'b1;
        repeat (2) cycle();
        idle();
        total++;
        if (bus.RAS_top !== 32'h100 || bus.RAS_empty !== 1'b0)
            $display("FAIL pop2 got top=%h empty=%b want top=100 empty=0", bus.RAS_top, bus.RAS_empty);
        else passed++;
    endtask

    task automatic test_overflow();
        logic [WIDTH-1:0] last;
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            bus.RAS_push = 1'b1;
            bus.RAS_push_data = WIDTH'(i);
            cycle();
        end
        idle();
        total++;
        if (bus.RAS_full !== 1'b1 || bus.RAS_top !== 32'd9)
            $display("FAIL ovf_full got full=%b top=%0d want full=1 top=9", bus.RAS_full, bus.RAS_top);
        else passed++;
        last = '0;
        for (int i = 0; i < 8; i++) begin
            last = bus.RAS_top;
            bus.RAS_pop = 1'b1;
            cycle();
        end
        total++;
        if (bus.RAS_empty !== 1'b1 || last !== 32'd2)
            $display("FAIL ovf_drain got empty=%b last=%0d want empty=1 last=2", bus.RAS_empty, last);
        else passed++;
        cycle();
        idle();
        total++;
        if (bus.RAS_top !== '0 || int'(dut.cnt) !== 0 || int'(dut.tp) !== 1)
            $display("FAIL underflow got top=%h cnt=%0d tp=%0d want top=0 cnt=0 tp=1",
                     bus.RAS_top, dut.cnt, dut.tp);
        else passed++;
    endtask

    task automatic test_rollback_ex();
        do_reset();
        bus.RAS_push = 1'b1;
        bus.RAS_push_data = 32'h10;
        cycle();
        bus.RAS_push_data = 32'h20;
        cycle();
        idle();
        bus.RAS_pop = 1'b1;
        cycle();
        cycle();
        idle();
        bus.RAS_rollback_push_id = 1'b1;
        bus.RAS_rollback_push_ex = 1'b1;
        cycle();
        idle();
        total++;
        if (bus.RAS_top !== 32'h20 || int'(dut.cnt) !== 2)
            $display("FAIL rb_two got top=%h cnt=%0d want top=20 cnt=2", bus.RAS_top, dut.cnt);
        else passed++;
        bus.RAS_pop = 1'b1;
        cycle();
        idle();
        total++;
        if (bus.RAS_top !== 32'h10)
            $display("FAIL rb_order got %h want 10", bus.RAS_top);
        else passed++;
    endtask

    task automatic test_push_pop_undo();
        do_reset();
        bus.RAS_push = 1'b1;
        bus.RAS_push_data = 32'h40;
        cycle();
        bus.RAS_pop = 1'b1;
        bus.RAS_push_data = 32'h80;
        cycle();
        idle();
        total++;
        if (bus.RAS_top !== 32'h80 || int'(dut.cnt) !== 1)
            $display("FAIL pushpop got top=%h cnt=%0d want top=80 cnt=1", bus.RAS_top, dut.cnt);
        else passed++;
        bus.RAS_rollback_pop_id  = 1'b1;
        bus.RAS_rollback_push_id = 1'b1;
        cycle();
        idle();
        total++;
        if (bus.RAS_top !== 32'h40 || int'(dut.cnt) !== 1)
            $display("FAIL pushpop_undo got top=%h cnt=%0d want top=40 cnt=1", bus.RAS_top, dut.cnt);
        else passed++;
    endtask

    task automatic test_stall();
        do_reset();
        bus.RAS_push = 1'b1;
        bus.RAS_push_data = 32'h55;
        cycle();
        bus.RAS_push_data = 32'h66;
        cycle();
        idle();
        bus.RAS_pop = 1'b1;
        cycle();
        idle();
        bus.PL_stall = 1'b1;
        repeat (3) cycle();
        total++;
        if (bus.RAS_top !== 32'h55 || int'(dut.cnt) !== 1)
            $display("FAIL stall_hold got top=%h cnt=%0d want top=55 cnt=1", bus.RAS_top, dut.cnt);
        else passed++;
        idle();
        cycle();
        bus.RAS_rollback_push_ex = 1'b1;
        cycle();
        idle();
        total++;
        if (bus.RAS_top !== 32'h66 || int'(dut.cnt) !== 2)
            $display("FAIL stall_restore got top=%h cnt=%0d want top=66 cnt=2", bus.RAS_top, dut.cnt);
        else passed++;
    endtask

    task automatic test_ra_track();
        do_reset();
        bus.WR_ra_track_en = 1'b1;
        bus.WR_ra_track_data = 5'd8;
        cycle();
        total++;
        if (bus.RAS_ra_track !== 5'd8) $display("FAIL ra_write got %0d want 8", bus.RAS_ra_track);
        else passed++;
        bus.WR_ra_track_en = 1'b0;
        bus.WR_ra_track_data = 5'd0;
        cycle();
        idle();
        total++;
        if (bus.RAS_ra_track !== 5'd8) $display("FAIL ra_hold got %0d want 8", bus.RAS_ra_track);
        else passed++;
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bus.RAS_push = 1'b1;
            bus.RAS_push_data = 32'hA0 + WIDTH'(i);
            cycle();
        end
        idle();
        bus.WR_ra_track_en = 1'b1;
        bus.WR_ra_track_data = 5'd8;
        cycle();
        idle();
        total++;
        if (int'(dut.cnt) !== 5 || bus.RAS_ra_track !== 5'd8)
            $display("FAIL pre_rst got cnt=%0d ra=%0d want cnt=5 ra=8", dut.cnt, bus.RAS_ra_track);
        else passed++;
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (int'(dut.cnt) !== 0 || bus.RAS_empty !== 1'b1 || bus.RAS_top !== '0 ||
            bus.RAS_ra_track !== 5'd1)
            $display("FAIL async_rst got cnt=%0d empty=%b top=%h ra=%0d want 0 1 0 1",
                     dut.cnt, bus.RAS_empty, bus.RAS_top, bus.RAS_ra_track);
        else passed++;
        #1;
        rst = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        int errs;
        int r;
        errs = 0;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            idle();
            bus.PL_stall = ($urandom_range(0, 3) == 0);
            r = int'($urandom_range(0, 9));
            if (r < 2) begin
                bus.RAS_rollback_pop_id  = $urandom_range(0, 1);
                bus.RAS_rollback_push_id = $urandom_range(0, 1);
                bus.RAS_rollback_push_ex = $urandom_range(0, 1);
            end else begin
                bus.RAS_push = ($urandom_range(0, 9) < 5);
                bus.RAS_pop  = ($urandom_range(0, 9) < 4);
                bus.RAS_push_data = $urandom;
            end
            bus.WR_ra_track_en   = ($urandom_range(0, 4) == 0);
            bus.WR_ra_track_data = 5'($urandom);
            cycle();
            total++;
            if (bus.RAS_top !== m_top() || int'(dut.cnt) !== q.size() ||
                bus.RAS_empty !== (q.size() == 0) || bus.RAS_full !== (q.size() == DEPTH) ||
                bus.RAS_ra_track !== m_ra) begin
                errs++;
                if (errs <= 5)
                    $display("FAIL rand_%0d got top=%h cnt=%0d e=%b f=%b ra=%0d want top=%h cnt=%0d ra=%0d",
                             n, bus.RAS_top, dut.cnt, bus.RAS_empty, bus.RAS_full,
                             bus.RAS_ra_track, m_top(), q.size(), m_ra);
            end else passed++;
        end
        idle();
    endtask

    initial begin
        idle();
        model_clear();
        test_reset();
        test_push_pop();
        test_overflow();
        test_rollback_ex();
        test_push_pop_undo();
        test_stall();
        test_ra_track();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
